softmax_exp_sequencer: RTL

Sequences the shared combinational float32 exp unit for the softmax stage of the MNIST output layer.
- Accepts N_CLASSES 8-bit logits on a valid/ready stream and buffers them while tracking the minimum.
- Drives the exp unit once per class with a min-shifted, saturated 8-bit argument.
- Streams the registered float32 results downstream with backpressure.
- Sits between the final dense layer and the normaliser.

---
 rtl/softmax_pkg.sv | 17 +
 rtl/softmax_logit_buffer.sv | 63 ++++++
 rtl/softmax_exp_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/softmax_pkg.sv
// Shared types and constants for the softmax exp sequencer.
// Optional build macro: ARGMAX_EN (adds argmax tracking and output).
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N_CLASSES_DEF = 10;

  localparam logic [31:0] EXP_ONE = 32'h3F80_0000;
  localparam logic [31:0] EXP_INF = 32'h7F80_0000;

endpackage

// File: rtl/softmax_logit_buffer.sv
// Logit register file with write pointer, running minimum and indexed read port.
// Under ARGMAX_EN it also tracks the index of the largest logit (lowest index wins ties).
module softmax_logit_buffer
  import softmax_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int IDX_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic [IDX_W-1:0] wr_idx,
  output logic [7:0]       min_val,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
`ifdef ARGMAX_EN
  ,
  output logic [IDX_W-1:0] max_idx
`endif
);

  localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N_CLASSES);

  logic [7:0] mem [N_CLASSES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CLASSES; k++) mem[k] <= '0;
      wr_idx  <= '0;
      min_val <= 8'hFF;
    end else if (clear) begin
      wr_idx  <= '0;
      min_val <= 8'hFF;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
      wr_idx      <= wr_idx + IDX_W'(1);
      if (wr_data < min_val) min_val <= wr_data;
    end
  end

  assign rd_data = (rd_idx < N_IDX) ? mem[rd_idx] : 8'h00;

`ifdef ARGMAX_EN
  logic [7:0] max_val;

  // Strict compare keeps the earliest index on ties; clear seeds index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (clear) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (wr_en && (wr_data > max_val)) begin
      max_val <= wr_data;
      max_idx <= wr_idx;
    end
  end
`endif

endmodule

// File: rtl/softmax_exp_sequencer.sv
// Buffers N_CLASSES logits, drives the external exp unit with min-shifted saturated
// arguments and streams registered float32 results. Optional macro: ARGMAX_EN.
module softmax_exp_sequencer
  import softmax_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int IDX_W     = 4,
  parameter int SAT_MAX   = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [7:0]       exp_x,
  input  logic [31:0]      exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             sat_seen,
  output logic             busy,
  output logic             done,
`ifdef ARGMAX_EN
  output logic [IDX_W-1:0] argmax,
`endif
  output state_t           dbg_state
);

  // Both streams transfer a beat on a rising edge where valid & ready are high;
  // a producer holds valid and its payload unchanged until that edge.

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);
  localparam logic [IDX_W:0]   N_CNT    = (IDX_W + 1)'(N_CLASSES);
  localparam logic [7:0]       SAT_LIM  = 8'(SAT_MAX);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       min_val;
  logic [7:0]       rd_data;
  logic [IDX_W:0]   iss_cnt;
  logic [7:0]       diff;
  logic             load_hs, load_last, iss_left, adv, out_hs, clamp, issue;

  assign in_ready  = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

  assign load_hs   = in_ready && in_valid;
  assign load_last = load_hs && (wr_idx == LAST_IDX);
  assign iss_left  = (iss_cnt < N_CNT);
  assign adv       = !out_valid || out_ready;
  assign out_hs    = out_valid && out_ready;
  assign diff      = rd_data - min_val;
  assign clamp     = (diff > SAT_LIM);
  assign issue     = (state == EXP) && adv && iss_left;

  softmax_logit_buffer #(
    .N_CLASSES (N_CLASSES),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state == IDLE) && start),
    .wr_en   (load_hs),
    .wr_data (in_data),
    .wr_idx  (wr_idx),
    .min_val (min_val),
    .rd_idx  (iss_cnt[IDX_W-1:0]),
    .rd_data (rd_data)
`ifdef ARGMAX_EN
    ,
    .max_idx (argmax)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    exp_x     = 8'h00;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: if (load_last) state_nxt = EXP;
      EXP: begin
        if (iss_left) exp_x = clamp ? SAT_LIM : diff;
        if (out_hs && out_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register: load a new result whenever the slot is free or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      sat_seen  <= 1'b0;
    end else begin
      if ((state == IDLE) && start) sat_seen <= 1'b0;
      if (load_last) iss_cnt <= '0;
      if (issue) begin
        out_valid <= 1'b1;
        out_data  <= exp_in;
        out_idx   <= iss_cnt[IDX_W-1:0];
        out_last  <= (iss_cnt[IDX_W-1:0] == LAST_IDX);
        iss_cnt   <= iss_cnt + (IDX_W + 1)'(1);
        if (clamp) sat_seen <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
